// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised rx, 3-sample majority vote per bit,
// glitch-rejecting start detection and a one-entry valid/ready output holding stage.
module uart_rx_cfg #(
  parameter int CLK_HZ      = 49_996_800,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int H   = CPB / 2;
  localparam int CW  = (CPB > 4) ? $clog2(CPB) : 2;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_INIT = (CPB - H + 2 >= CPB) ? '0 : CW'(CPB - H + 2);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2) begin : g_param_check
    $error("uart_rx_cfg: illegal parameter combination");
  end

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [3:0]             r_bit;
  logic                   r_s0;
  logic                   r_s1;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_fe;
  logic                   r_pe;
  logic                   w_rxs;
  logic                   w_start;
  logic                   w_dec;
  logic                   w_vote;
  logic                   w_par_exp;
  logic                   w_done;
  logic                   w_take;

  assign w_rxs     = r_sync[SYNC_STAGES-1];
  assign w_start   = (r_state == S_IDLE) && r_prev && !w_rxs;
  // Phase 0/1/2 of the bit counter are centre-1, centre, centre+1.
  assign w_dec     = (r_state != S_IDLE) && (r_cnt == CW'(2));
  assign w_vote    = maj3(r_s0, r_s1, w_rxs);
  assign w_par_exp = (PARITY == 1) ? ~(^r_shift) : ^r_shift;
  assign w_done    = w_dec && (r_state == S_STOP) && (r_bit == LAST_STOP);
  assign w_take    = !valid || ready;
  assign busy      = (r_state != S_IDLE);

  // r_fill masks the synchroniser reset value so a line low out of reset is no edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
      r_fill <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev <= r_fill[SYNC_STAGES-1] & w_rxs;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_start) begin
        r_state <= S_START;
        r_cnt   <= CNT_INIT;
        r_bit   <= '0;
        r_fe    <= 1'b0;
        r_pe    <= 1'b0;
      end
    end else begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);
      if (w_dec) begin
        case (r_state)
          S_START: r_state <= w_vote ? S_IDLE : S_DATA;
          S_DATA: begin
            if (r_bit == LAST_DATA) begin
              r_bit   <= '0;
              r_state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
          S_PAR: begin
            r_pe    <= (w_vote != w_par_exp);
            r_state <= S_STOP;
          end
          S_STOP: begin
            if (!w_vote) r_fe <= 1'b1;
            if (r_bit == LAST_STOP) r_state <= S_IDLE;
            else r_bit <= r_bit + 4'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (r_state != S_IDLE) begin
      if (r_cnt == '0) r_s0 <= w_rxs;
      if (r_cnt == CW'(1)) r_s1 <= w_rxs;
      if (w_dec && r_state == S_DATA) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
    end
  end

  // A completion while an unaccepted character is held is dropped and flagged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= w_done && !w_take;
      if (w_done && w_take) begin
        valid      <= 1'b1;
        data       <= r_shift;
        frame_err  <= r_fe || !w_vote;
        parity_err <= r_pe;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance driven with directed
// and random frames; delivered characters are compared with frame-level expectations.
module tb_uart_rx_cfg;
  localparam int CPB_A = 16;
  localparam int CPB_B = 13;
  localparam int SA    = 2;
  localparam int SB    = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a = 1'b0, rx_b = 1'b0;
  logic       ready_a = 1'b0, ready_b = 1'b1;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, fe_a, pe_a, overrun_a, busy_a;
  logic       valid_b, fe_b, pe_b, overrun_b, busy_b;

  uart_rx_cfg #(.CLK_HZ(CPB_A * 1000), .BAUD(1000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .SYNC_STAGES(SA)) u_a (
    .clock(clock), .reset(reset), .rx(rx_a), .data(data_a), .valid(valid_a),
    .ready(ready_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(overrun_a), .busy(busy_a));

  uart_rx_cfg #(.CLK_HZ(CPB_B * 1000), .BAUD(1000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .SYNC_STAGES(SB)) u_b (
    .clock(clock), .reset(reset), .rx(rx_b), .data(data_b), .valid(valid_b),
    .ready(ready_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(overrun_b), .busy(busy_b));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          n_vec = 0, n_err = 0;
  bit          sel_b = 1'b0;
  int          t_start = 0;
  logic [10:0] q_a[$], q_b[$], exp_a[$], exp_b[$];
  int          ovr_a = 0, ovr_b = 0, viol_a = 0, viol_b = 0, rise_a = 0, rise_b = 0;
  logic        pv_a = 1'b0, ph_a = 1'b0, pv_b = 1'b0, ph_b = 1'b0;
  logic [9:0]  pw_a = '0;
  logic [8:0]  pw_b = '0;

  // Monitor: samples just after the falling edge, once inputs have settled.
  always begin
    @(negedge clock);
    #1;
    if (!reset) begin
      if (valid_a && ready_a) q_a.push_back({1'b0, fe_a, pe_a, data_a});
      if (valid_b && ready_b) q_b.push_back({2'b00, fe_b, pe_b, data_b});
      if (overrun_a) ovr_a <= ovr_a + 1;
      if (overrun_b) ovr_b <= ovr_b + 1;
      if (valid_a && !pv_a) rise_a <= cyc;
      if (valid_b && !pv_b) rise_b <= cyc;
      if (pv_a && !ph_a && {fe_a, pe_a, data_a} !== pw_a) viol_a <= viol_a + 1;
      if (pv_b && !ph_b && {fe_b, pe_b, data_b} !== pw_b) viol_b <= viol_b + 1;
    end
    pv_a <= valid_a && !reset;
    ph_a <= valid_a && ready_a;
    pw_a <= {fe_a, pe_a, data_a};
    pv_b <= valid_b && !reset;
    ph_b <= valid_b && ready_b;
    pw_b <= {fe_b, pe_b, data_b};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v);
    if (sel_b) rx_b = v;
    else rx_a = v;
  endtask

  // Drives a frame (bit 0 first) for up to 'cut' clocks; 'spike' inverts the line
  // for one clock at each bit centre.
  task automatic send(input logic [15:0] w, input int nbits, input bit spike, input int cut);
    int cpb;
    cpb = sel_b ? CPB_B : CPB_A;
    t_start = cyc;
    for (int j = 0; j < nbits * cpb && j < cut; j++) begin
      drive(w[j / cpb] ^ (spike && ((j % cpb) == cpb / 2)));
      @(negedge clock);
    end
    drive(1'b1);
  endtask

  task automatic wait_to(input int tgt);
    while (cyc < tgt) @(negedge clock);
  endtask

  function automatic logic [15:0] fa(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] fb(input logic [6:0] d, input logic p, input logic s1,
                                     input logic s2);
    return {5'b0, s2, s1, p, d, 1'b0};
  endfunction

  // Even parity: the parity bit should equal the XOR of the data bits.
  function automatic logic [10:0] ex_b(input logic [6:0] d, input logic p, input logic s1,
                                       input logic s2);
    return {2'b00, ~(s1 & s2), p ^ (^d), d};
  endfunction

  task automatic cmp_a(input string tag);
    chk({tag, "_count"}, q_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < q_a.size(); i++) chk(tag, 32'(q_a[i]), 32'(exp_a[i]));
    q_a.delete();
    exp_a.delete();
  endtask

  task automatic cmp_b(input string tag);
    chk({tag, "_count"}, q_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < q_b.size(); i++) chk(tag, 32'(q_b[i]), 32'(exp_b[i]));
    q_b.delete();
    exp_b.delete();
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL timeout: simulation exceeded its cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic [6:0] db;
    logic       p, s1, s2;
    bit         sp;
    int         o0;

    repeat (3) @(negedge clock);
    chk("rst_data_a", data_a, 0);
    chk("rst_valid_a", valid_a, 0);
    chk("rst_fe_a", fe_a, 0);
    chk("rst_pe_a", pe_a, 0);
    chk("rst_ovr_a", overrun_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_valid_b", valid_b, 0);
    chk("rst_busy_b", busy_b, 0);

    // Line held low from reset must not look like a start.
    reset = 1'b0;
    repeat (3 * CPB_A) @(negedge clock);
    chk("low_after_rst_a", busy_a, 0);
    chk("low_after_rst_b", busy_b, 0);
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (4) @(negedge clock);

    ready_a = 1'b0;
    send(fa(8'h0F), 10, 1'b0, 1000);
    repeat (4) @(negedge clock);
    chk("latency_a", rise_a, t_start + SA + CPB_A / 2 + 9 * CPB_A + 2);
    chk("valid_0f", valid_a, 1);
    chk("data_0f", data_a, 8'h0F);
    chk("fe_0f", fe_a, 0);
    chk("pe_0f", pe_a, 0);
    repeat (5) @(negedge clock);
    chk("hold_0f", valid_a, 1);
    ready_a = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("drop_0f", valid_a, 0);
    exp_a.push_back(11'h00F);
    cmp_a("ch_0f");

    t_start = cyc;
    rx_a = 1'b0;
    repeat (4) @(negedge clock);
    rx_a = 1'b1;
    wait_to(t_start + SA + CPB_A / 2);
    chk("glitch_busy_hi", busy_a, 1);
    wait_to(t_start + SA + CPB_A / 2 + 2);
    chk("glitch_busy_lo", busy_a, 0);
    repeat (2 * CPB_A) @(negedge clock);
    chk("glitch_valid", valid_a, 0);
    cmp_a("glitch");

    send(fa(8'hA5), 10, 1'b0, 1000);
    exp_a.push_back(11'h0A5);
    send(fa(8'h55), 10, 1'b1, 1000);
    exp_a.push_back(11'h055);
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      sp = 1'($urandom_range(0, 1));
      send(fa(d), 10, sp, 1000);
      exp_a.push_back({3'b000, d});
    end
    repeat (3 * CPB_A) @(negedge clock);
    cmp_a("rand_a");

    ready_a = 1'b0;
    o0 = ovr_a;
    send(fa(8'h11), 10, 1'b0, 1000);
    send(fa(8'h22), 10, 1'b0, 1000);
    repeat (2 * CPB_A) @(negedge clock);
    chk("ovr_valid", valid_a, 1);
    chk("ovr_data", data_a, 8'h11);
    chk("ovr_pulses", ovr_a - o0, 1);
    ready_a = 1'b1;
    repeat (3) @(negedge clock);
    chk("ovr_drained", valid_a, 0);
    exp_a.push_back(11'h011);
    cmp_a("ovr_hs");
    send(fa(8'h11), 10, 1'b0, 1000);
    send(fa(8'h22), 10, 1'b0, 1000);
    exp_a.push_back(11'h011);
    exp_a.push_back(11'h022);
    repeat (2 * CPB_A) @(negedge clock);
    cmp_a("b2b_rdy");

    send(fa(8'h3C), 10, 1'b0, 4 * CPB_A + CPB_A / 2);
    reset = 1'b1;
    #1;
    chk("midrst_data", data_a, 0);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ovr", overrun_a, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3 * CPB_A) @(negedge clock);
    cmp_a("midrst_none");
    send(fa(8'h3C), 10, 1'b0, 1000);
    exp_a.push_back(11'h03C);
    repeat (2 * CPB_A) @(negedge clock);
    cmp_a("after_rst");

    sel_b = 1'b1;
    ready_b = 1'b1;
    send(fb(7'h41, 1'b0, 1'b1, 1'b1), 11, 1'b0, 1000);
    repeat (4) @(negedge clock);
    chk("latency_b", rise_b, t_start + SB + CPB_B / 2 + 10 * CPB_B + 2);
    exp_b.push_back(ex_b(7'h41, 1'b0, 1'b1, 1'b1));
    send(fb(7'h41, 1'b1, 1'b1, 1'b1), 11, 1'b0, 1000);
    exp_b.push_back(ex_b(7'h41, 1'b1, 1'b1, 1'b1));
    repeat (2 * CPB_B) @(negedge clock);
    cmp_b("par_b");

    send(fb(7'h33, ^7'h33, 1'b0, 1'b0), 11, 1'b0, 1000);
    rx_b = 1'b0;
    repeat (3 * CPB_B) @(negedge clock);
    rx_b = 1'b1;
    repeat (CPB_B) @(negedge clock);
    send(fb(7'h12, ^7'h12, 1'b1, 1'b1), 11, 1'b0, 1000);
    exp_b.push_back(ex_b(7'h33, ^7'h33, 1'b0, 1'b0));
    exp_b.push_back(ex_b(7'h12, ^7'h12, 1'b1, 1'b1));
    repeat (2 * CPB_B) @(negedge clock);
    cmp_b("break_b");

    for (int i = 0; i < 12; i++) begin
      db = 7'($urandom);
      p  = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      sp = 1'($urandom_range(0, 1));
      send(fb(db, p, s1, s2), 11, sp, 1000);
      exp_b.push_back(ex_b(db, p, s1, s2));
      if (!s2) repeat (CPB_B) @(negedge clock);
    end
    repeat (3 * CPB_B) @(negedge clock);
    cmp_b("rand_b");

    chk("stable_a", viol_a, 0);
    chk("stable_b", viol_b, 0);
    chk("no_ovr_b", ovr_b, 0);
    chk("ovr_total_a", ovr_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
